// File: rtl/traffic_pkg.sv
// Shared phase codes and light encodings for the intersection scheduler.
// Light vectors are {red,yellow,green} with exactly one bit set.
package traffic_pkg;

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR_A = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR_B = 3'd5
   } phase_e;

   localparam logic [2:0] LIGHT_R = 3'b100;
   localparam logic [2:0] LIGHT_Y = 3'b010;
   localparam logic [2:0] LIGHT_G = 3'b001;

   function automatic logic [2:0] ns_light_of(input phase_e p);
      case (p)
         NS_G:    return LIGHT_G;
         NS_Y:    return LIGHT_Y;
         default: return LIGHT_R;
      endcase
   endfunction

   function automatic logic [2:0] ew_light_of(input phase_e p);
      case (p)
         EW_G:    return LIGHT_G;
         EW_Y:    return LIGHT_Y;
         default: return LIGHT_R;
      endcase
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Tick-driven dwell counter: done pulses on the tick that completes dur ticks.
// clr has priority over counting so a phase change and a hold both restart at 0.
module dwell_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             tick,
   input  logic [CNT_W-1:0] dur,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = tick & (cnt_q == (dur - CNT_W'(1)));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Six-phase two-head intersection sequencer with all-red clearance, latched
// pedestrian walk service and emergency preemption. phase is the FSM state.
import traffic_pkg::*;

module intersection_phase_scheduler #(
   parameter int CNT_W    = 8,
   parameter int GREEN_T  = 20,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int PED_T    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       ped_req_ns,
   input  logic       ped_req_ew,
   input  logic       emerg,
   input  logic       emerg_dir,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase,
   output logic [1:0] ped_pending
);

   phase_e           phase_q, phase_d;
   logic [1:0]       pend_q, pend_d;
   logic             walk_ns_q, walk_ns_d;
   logic             walk_ew_q, walk_ew_d;
   logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
   logic [2:0]       ns_light_q, ns_light_d;
   logic [2:0]       ew_light_q, ew_light_d;
   logic [CNT_W-1:0] dur;
   logic             hold;
   logic             enter;
   logic             tmr_done;
   logic             walk_end;
   logic [1:0]       serve;

   always_comb begin
      case (phase_q)
         NS_G, EW_G: dur = CNT_W'(GREEN_T);
         NS_Y, EW_Y: dur = CNT_W'(YELLOW_T);
         default:    dur = CNT_W'(ALLRED_T);
      endcase
   end

   dwell_timer #(.CNT_W(CNT_W)) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .clr  (hold | enter),
      .tick (tick),
      .dur  (dur),
      .done (tmr_done)
   );

   // Preemption is checked before expiry so it wins in the same clk.
   always_comb begin
      phase_d = phase_q;
      hold    = 1'b0;
      case (phase_q)
         NS_G: begin
            if (emerg && emerg_dir)  phase_d = NS_Y;
            else if (emerg)          hold    = 1'b1;
            else if (tmr_done)       phase_d = NS_Y;
         end
         NS_Y: if (tmr_done) phase_d = AR_A;
         AR_A: if (tmr_done) phase_d = EW_G;
         EW_G: begin
            if (emerg && !emerg_dir) phase_d = EW_Y;
            else if (emerg)          hold    = 1'b1;
            else if (tmr_done)       phase_d = EW_Y;
         end
         EW_Y: if (tmr_done) phase_d = AR_B;
         AR_B: if (tmr_done) phase_d = NS_G;
         default: phase_d = AR_B;
      endcase
   end

   assign enter = (phase_d != phase_q);

   // A walk is not granted into a green that is about to be held for preemption.
   always_comb begin
      serve = 2'b00;
      if (enter && phase_d == NS_G && pend_q[0] && !(emerg && !emerg_dir)) serve[0] = 1'b1;
      if (enter && phase_d == EW_G && pend_q[1] && !(emerg && emerg_dir))  serve[1] = 1'b1;
      pend_d   = (pend_q & ~serve) | {ped_req_ew, ped_req_ns};
      walk_end = tick && (walk_cnt_q == CNT_W'(PED_T - 1));
      walk_ns_d = serve[0] |
                  (walk_ns_q & (phase_d == NS_G) & ~enter & ~hold & ~walk_end);
      walk_ew_d = serve[1] |
                  (walk_ew_q & (phase_d == EW_G) & ~enter & ~hold & ~walk_end);
      walk_cnt_d = walk_cnt_q;
      if (enter) begin
         walk_cnt_d = '0;
      end else if (tick && (walk_ns_q || walk_ew_q)) begin
         walk_cnt_d = walk_cnt_q + CNT_W'(1);
      end
      ns_light_d = ns_light_of(phase_d);
      ew_light_d = ew_light_of(phase_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= AR_B;
         pend_q     <= 2'b00;
         walk_ns_q  <= 1'b0;
         walk_ew_q  <= 1'b0;
         walk_cnt_q <= '0;
         ns_light_q <= LIGHT_R;
         ew_light_q <= LIGHT_R;
      end else begin
         phase_q    <= phase_d;
         pend_q     <= pend_d;
         walk_ns_q  <= walk_ns_d;
         walk_ew_q  <= walk_ew_d;
         walk_cnt_q <= walk_cnt_d;
         ns_light_q <= ns_light_d;
         ew_light_q <= ew_light_d;
      end
   end

   assign phase       = phase_q;
   assign ns_light    = ns_light_q;
   assign ew_light    = ew_light_q;
   assign walk_ns     = walk_ns_q;
   assign walk_ew     = walk_ew_q;
   assign ped_pending = pend_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: per-clk expected outputs are queued by the
// driver from a ticks-remaining reference model and checked by an independent monitor.
module tb_intersection_phase_scheduler;

   localparam int CNT_W    = 8;
   localparam int GREEN_T  = 4;
   localparam int YELLOW_T = 2;
   localparam int ALLRED_T = 1;
   localparam int PED_T    = 3;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       ped_req_ns;
   logic       ped_req_ew;
   logic       emerg;
   logic       emerg_dir;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk_ns;
   logic       walk_ew;
   logic [2:0] phase;
   logic [1:0] ped_pending;

   intersection_phase_scheduler #(
      .CNT_W(CNT_W), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
      .ALLRED_T(ALLRED_T), .PED_T(PED_T)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick),
      .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
      .emerg(emerg), .emerg_dir(emerg_dir),
      .ns_light(ns_light), .ew_light(ew_light),
      .walk_ns(walk_ns), .walk_ew(walk_ew),
      .phase(phase), .ped_pending(ped_pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {phase, ns_light, ew_light, walk_ns, walk_ew, ped_pending}
   logic [12:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        done     = 1'b0;

   // Reference model: phase index, ticks left in the phase, walk ticks left per direction.
   int         m_ph;
   int         m_rem;
   int         m_walk[2];
   logic [1:0] m_pend;
   int         dur_tab[6]   = '{GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T};
   logic [2:0] ns_tab[6]    = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
   logic [2:0] ew_tab[6]    = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

   task automatic model_step(input logic r, input logic t, input logic pn,
                             input logic pe, input logic em, input logic ed);
      int  gd;
      int  nph;
      int  x;
      bit  green;
      bit  moved;
      if (r) begin
         m_ph = 5; m_rem = ALLRED_T; m_pend = 2'b00;
         m_walk[0] = 0; m_walk[1] = 0;
         return;
      end
      green = (m_ph == 0) || (m_ph == 3);
      gd    = (m_ph == 3) ? 1 : 0;
      nph   = m_ph;
      moved = 1'b0;
      if (green && em && (int'(ed) != gd)) begin
         nph = m_ph + 1; moved = 1'b1;
      end else if (green && em) begin
         m_rem = GREEN_T; m_walk[gd] = 0;
      end else if (t) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) begin
            nph = (m_ph + 1) % 6; moved = 1'b1;
         end else if (green && m_walk[gd] > 0) begin
            m_walk[gd] = m_walk[gd] - 1;
         end
      end
      if (moved) begin
         m_walk[0] = 0; m_walk[1] = 0;
         m_ph  = nph;
         m_rem = dur_tab[nph];
         if (nph == 0 || nph == 3) begin
            x = (nph == 3) ? 1 : 0;
            if (m_pend[x] && !(em && int'(ed) == x)) begin
               m_pend[x] = 1'b0;
               m_walk[x] = PED_T;
            end
         end
      end
      m_pend = m_pend | {pe, pn};
   endtask

   function automatic logic [12:0] model_out();
      return {3'(m_ph), ns_tab[m_ph], ew_tab[m_ph],
              m_walk[0] > 0, m_walk[1] > 0, m_pend};
   endfunction

   task automatic step(input logic r, input logic t, input logic pn,
                       input logic pe, input logic em, input logic ed);
      rst = r; tick = t; ped_req_ns = pn; ped_req_ew = pe; emerg = em; emerg_dir = ed;
      model_step(r, t, pn, pe, em, ed);
      exp_q.push_back(model_out());
      @(negedge clk);
   endtask

   // Ticks every clk until the model reaches phase ph (and ticks-left rem if rem >= 0).
   task automatic run_until(input int ph, input int rem, input string name);
      int budget;
      budget = 200;
      while (!(m_ph == ph && (rem < 0 || m_rem == rem)) && budget > 0) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         budget--;
      end
      n_checks++;
      if (budget == 0) begin
         n_fail++;
         $display("FAIL %s: wait budget expired, phase=%0d required=%0d", name, m_ph, ph);
      end
   endtask

   initial begin : monitor
      logic [12:0] exp;
      logic [12:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            if (!done) begin
               n_checks++; n_fail++;
               $display("FAIL sb_empty: output at %0t with no expectation queued", $time);
            end
         end else begin
            exp = exp_q.pop_front();
            act = {phase, ns_light, ew_light, walk_ns, walk_ew, ped_pending};
            n_checks++;
            if (act !== exp) begin
               n_fail++;
               $display("FAIL outputs @%0t: got ph=%0d ns=%b ew=%b walk=%b%b pend=%b, required ph=%0d ns=%b ew=%b walk=%b%b pend=%b",
                        $time, act[12:10], act[9:7], act[6:4], act[3], act[2], act[1:0],
                        exp[12:10], exp[9:7], exp[6:4], exp[3], exp[2], exp[1:0]);
            end
            n_checks++;
            if (ns_light != 3'b100 && ew_light != 3'b100) begin
               n_fail++;
               $display("FAIL green_conflict @%0t: ns=%b ew=%b, required one head red",
                        $time, ns_light, ew_light);
            end
         end
      end
   end

   initial begin : driver
      logic em;
      logic ed;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Free-running cycle, tick every clk.
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // EW request during NS green is served at the next EW green.
      run_until(0, -1, "wait_ns_g_ew_req");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // NS request during NS green waits for the following NS green.
      run_until(0, -1, "wait_ns_g_ns_req");
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Request landing in the same clk as the green entry stays pending.
      run_until(2, -1, "wait_ar_a");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Preempt toward EW from NS green at timer = 1, hold EW green, then release.
      run_until(0, GREEN_T - 1, "wait_ns_g_t1");
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Direction flips while held in EW green.
      run_until(3, -1, "wait_ew_g");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Sparse timebase: tick every third clk with random requests.
      for (int i = 0; i < 90; i++)
         step(1'b0, (i % 3) == 2, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              1'b0, 1'b0);

      // Reset mid EW yellow with both requests pending.
      run_until(3, -1, "wait_ew_g_rst");
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      run_until(4, -1, "wait_ew_y_rst");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random soak with emergency levels and rare resets.
      em = 1'b0;
      ed = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            em = ~em;
            ed = 1'($urandom_range(0, 1));
         end else if (em && $urandom_range(0, 39) == 0) begin
            ed = ~ed;
         end
         step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, em, ed);
      end

      done = 1'b1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
